// File: rtl/mcac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcac_pkg
// Description : Shared definitions for the ADPCM bitstream path: RATE
//               encodings, code-width lookup and the unpacker alignment
//               state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package mcac_pkg;

    // RATE field encodings (code width 2..5 bits)
    localparam logic [1:0] RATE_16K = 2'b00;
    localparam logic [1:0] RATE_24K = 2'b01;
    localparam logic [1:0] RATE_32K = 2'b10;
    localparam logic [1:0] RATE_40K = 2'b11;

    // Unpacker alignment states
    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_SYNC = 1'b1
    } bs_state_t;

    // Number of bits per code word for a RATE encoding
    function automatic logic [2:0] rate_bits(input logic [1:0] rate);
        logic [2:0] nb;
        case (rate)
            RATE_16K: nb = 3'd2;
            RATE_24K: nb = 3'd3;
            RATE_32K: nb = 3'd4;
            default:  nb = 3'd5;
        endcase
        return nb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bs_shift.sv
`default_nettype none
// ============================================================================
// Module      : bs_shift
// Description : Code-word shift register and bit counter for the bitstream
//               unpacker. A code of up to 5 bits is assembled MSB first.
//               'done' flags that the bit being shifted in this cycle is the
//               last bit of the code; 'code' is then the complete word.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               load        - start a new code with bit_in as its MSB
//               shift       - append bit_in to the current code
//               clear       - discard any partial code
//               bit_in      - serial bit
//               nbits       - code width (2..5)
//               code        - code value including bit_in, right-aligned
//               done        - this shift completes the code
// Revision    : 1.0  initial release
// ============================================================================
module bs_shift (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic       clear,
    input  logic       bit_in,
    input  logic [2:0] nbits,
    output logic [4:0] code,
    output logic       done
);

    // Only four bits ever need to be held: the fifth bit of a 5-bit code is
    // the incoming bit itself, and the word is handed off in that same cycle.
    logic [3:0] r_data;
    logic [2:0] r_count;
    logic [2:0] w_count_inc;

    assign w_count_inc = r_count + 3'd1;
    assign code        = {r_data, bit_in};
    assign done        = shift && !load && !clear && (w_count_inc == nbits);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_data  <= 4'd0;
            r_count <= 3'd0;
        end else if (load) begin
            // Upper bits cleared so shorter codes come out zero-extended
            r_data  <= {3'd0, bit_in};
            r_count <= 3'd1;
        end else if (shift) begin
            if (done) begin
                r_data  <= 4'd0;
                r_count <= 3'd0;
            end else begin
                r_data  <= code[3:0];
                r_count <= w_count_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adpcm_bs_unpack.sv
`default_nettype none
// ============================================================================
// Module      : adpcm_bs_unpack
// Description : Receive-side TDM bitstream unpacker. Aligns to the frame
//               sync strobe and extracts one variable-width ADPCM code per
//               channel per frame, presented over a valid/ready handshake.
//               Optional macro BS_FRAME_CHECK_EN enables frame-error
//               detection (FERR pulse, return to HUNT on a missing FS).
// Ports       : clk, reset      - clock, synchronous active-high reset
//               BS, BSV, FS     - serial bit, bit strobe, frame sync
//               RATE            - code width select, latched on FS
//               I, CH, IV, IR   - code, channel, valid, consumer ready
//               OVR             - sticky overrun flag
//               FERR            - one-cycle frame error pulse
//               scan_*          - reserved for scan insertion
// Revision    : 1.0  initial release
// ============================================================================
module adpcm_bs_unpack
    import mcac_pkg::*;
#(
    parameter int NCH = 32,
    parameter int CHW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           BS,
    input  logic           BSV,
    input  logic           FS,
    input  logic [1:0]     RATE,
    output logic [4:0]     I,
    output logic [CHW-1:0] CH,
    output logic           IV,
    input  logic           IR,
    output logic           OVR,
    output logic           FERR,
    input  logic           scan_in0,
    input  logic           scan_in1,
    input  logic           scan_in2,
    input  logic           scan_in3,
    input  logic           scan_in4,
    input  logic           scan_enable,
    input  logic           test_mode,
    output logic           scan_out0,
    output logic           scan_out1,
    output logic           scan_out2,
    output logic           scan_out3,
    output logic           scan_out4
);

    localparam logic [CHW-1:0] C_LAST_CH = CHW'(NCH - 1);

    bs_state_t      r_state;
    logic [2:0]     r_nbits;
    logic [CHW-1:0] r_ch;
    logic           r_frame_done;
    logic [4:0]     r_i;
    logic [CHW-1:0] r_ch_out;
    logic           r_iv;
    logic           r_ovr;
    logic           r_ferr;

    logic           w_load;
    logic           w_shift;
    logic           w_clear;
    logic           w_done;
    logic [4:0]     w_code;
    logic           w_unused_scan;

    // A bit arriving after the frame is complete without FS: either it is
    // rejected (frame check) or it restarts channel 0 in free-running mode.
    always_comb begin
        w_load  = BSV && FS;
        w_shift = BSV && !FS && (r_state == ST_SYNC) && !r_frame_done;
        w_clear = 1'b0;
`ifdef BS_FRAME_CHECK_EN
        if (BSV && !FS && (r_state == ST_SYNC) && r_frame_done) begin
            w_clear = 1'b1;
        end
`else
        if (BSV && !FS && (r_state == ST_SYNC) && r_frame_done) begin
            w_load = 1'b1;
        end
`endif
    end

    bs_shift u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .shift  (w_shift),
        .clear  (w_clear),
        .bit_in (BS),
        .nbits  (r_nbits),
        .code   (w_code),
        .done   (w_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_HUNT;
            r_nbits      <= rate_bits(RATE_32K);
            r_ch         <= '0;
            r_frame_done <= 1'b0;
            r_i          <= 5'd0;
            r_ch_out     <= '0;
            r_iv         <= 1'b0;
            r_ovr        <= 1'b0;
            r_ferr       <= 1'b0;
        end else begin
            r_ferr <= 1'b0;

            // Alignment and channel tracking
            if (BSV) begin
                if (FS) begin
`ifdef BS_FRAME_CHECK_EN
                    if ((r_state == ST_SYNC) && !r_frame_done) begin
                        r_ferr <= 1'b1;
                    end
`endif
                    r_nbits      <= rate_bits(RATE);
                    r_ch         <= '0;
                    r_frame_done <= 1'b0;
                    r_state      <= ST_SYNC;
                end else if (r_state == ST_SYNC) begin
                    if (r_frame_done) begin
`ifdef BS_FRAME_CHECK_EN
                        r_ferr  <= 1'b1;
                        r_state <= ST_HUNT;
`endif
                        r_ch         <= '0;
                        r_frame_done <= 1'b0;
                    end else if (w_done) begin
                        if (r_ch == C_LAST_CH) begin
                            r_ch         <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_ch <= r_ch + CHW'(1);
                        end
                    end
                end
            end

            // Output register and handshake; a new code always wins
            if (w_done) begin
                r_i      <= w_code;
                r_ch_out <= r_ch;
                r_iv     <= 1'b1;
                if (r_iv && !IR) begin
                    r_ovr <= 1'b1;
                end
            end else if (r_iv && IR) begin
                r_iv <= 1'b0;
            end
        end
    end

    assign I    = r_i;
    assign CH   = r_ch_out;
    assign IV   = r_iv;
    assign OVR  = r_ovr;
    assign FERR = r_ferr;

    assign w_unused_scan = &{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                             scan_enable, test_mode};
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_adpcm_bs_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_adpcm_bs_unpack
// Description : Directed self-checking bench for adpcm_bs_unpack (NCH=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_adpcm_bs_unpack;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       BS = 1'b0, BSV = 1'b0, FS = 1'b0, IR = 1'b1;
    logic [1:0] RATE = 2'b10;
    logic [4:0] I;
    logic [1:0] CH;
    logic       IV, OVR, FERR;
    logic       so0, so1, so2, so3, so4;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BS_FRAME_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    adpcm_bs_unpack #(.NCH(4), .CHW(2)) dut (
        .clk(clk), .reset(reset), .BS(BS), .BSV(BSV), .FS(FS), .RATE(RATE),
        .I(I), .CH(CH), .IV(IV), .IR(IR), .OVR(OVR), .FERR(FERR),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0),
        .scan_in4(1'b0), .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3),
        .scan_out4(so4)
    );

    always #5 clk = ~clk;

    // Present one bit for exactly one edge; outputs are observed 1 time unit later
    task automatic drive_bit(input logic b, input logic f);
        BS = b; FS = f; BSV = 1'b1;
        @(posedge clk); #1;
        BSV = 1'b0; FS = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; BSV = 1'b0; FS = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({I, CH, IV, OVR, FERR} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset: got I=%h CH=%0d IV=%b OVR=%b FERR=%b want all 0", I, CH, IV, OVR, FERR);
        end
    endtask

    task automatic test_four_bit();
        logic [15:0] s;
        logic [4:0]  e [0:3];
        s = 16'b1010_0111_0001_1111;
        e[0] = 5'h0A; e[1] = 5'h07; e[2] = 5'h01; e[3] = 5'h0F;
        do_reset(); RATE = 2'b10; IR = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_bit(s[15-i], i == 0);
            n_tests++;
            if (i % 4 == 3) begin
                if ({IV, I, CH} !== {1'b1, e[i/4], 2'(i/4)}) begin
                    n_fail++;
                    $display("FAIL four_bit[%0d]: got IV=%b I=%h CH=%0d want IV=1 I=%h CH=%0d", i, IV, I, CH, e[i/4], i/4);
                end
            end else if (IV !== 1'b0) begin
                n_fail++;
                $display("FAIL four_bit_iv[%0d]: got IV=%b want 0", i, IV);
            end
        end
    endtask

    task automatic test_rate_switch();
        do_reset(); RATE = 2'b00; IR = 1'b1;
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, I, CH} !== {1'b1, 5'h03, 2'd0}) begin
            n_fail++;
            $display("FAIL rate2_c0: got IV=%b I=%h CH=%0d want 1 03 0", IV, I, CH);
        end
        drive_bit(1'b0, 1'b0);
        n_tests++;
        if (IV !== 1'b0) begin
            n_fail++;
            $display("FAIL rate2_gap: got IV=%b want 0", IV);
        end
        drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, I, CH} !== {1'b1, 5'h01, 2'd1}) begin
            n_fail++;
            $display("FAIL rate2_c1: got IV=%b I=%h CH=%0d want 1 01 1", IV, I, CH);
        end
        // New FS latches RATE=11; a RATE change mid-code must be ignored
        RATE = 2'b11;
        drive_bit(1'b1, 1'b1);
        RATE = 2'b00;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        n_tests++;
        if (IV !== 1'b0) begin
            n_fail++;
            $display("FAIL rate5_early: got IV=%b want 0 after 4 of 5 bits", IV);
        end
        drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, I, CH} !== {1'b1, 5'h13, 2'd0}) begin
            n_fail++;
            $display("FAIL rate5: got IV=%b I=%h CH=%0d want 1 13 0", IV, I, CH);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s;
        logic [4:0] e [0:3];
        s = 8'b10_01_11_00;
        e[0] = 5'h02; e[1] = 5'h01; e[2] = 5'h03; e[3] = 5'h00;
        do_reset(); RATE = 2'b00; IR = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_bit(s[7-i], i == 0);
            if (i % 2 == 1) begin
                n_tests++;
                if ({IV, I, CH} !== {1'b1, e[i/2], 2'(i/2)}) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got IV=%b I=%h CH=%0d want 1 %h %0d", i, IV, I, CH, e[i/2], i/2);
                end
            end
        end
        // Frame complete; next bit arrives without FS
        drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, FERR} !== {1'b0, CHK}) begin
            n_fail++;
            $display("FAIL nofs_first: got IV=%b FERR=%b want 0 %b", IV, FERR, CHK);
        end
        drive_bit(1'b1, 1'b0);
        n_tests++;
        if (CHK) begin
            if ({IV, FERR} !== 2'b00) begin
                n_fail++;
                $display("FAIL nofs_hunt: got IV=%b FERR=%b want 0 0", IV, FERR);
            end
        end else if ({IV, I, CH, FERR} !== {1'b1, 5'h03, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL nofs_wrap: got IV=%b I=%h CH=%0d FERR=%b want 1 03 0 0", IV, I, CH, FERR);
        end
    endtask

    task automatic test_hunt();
        do_reset(); RATE = 2'b10; IR = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_bit(i[0], 1'b0);
            n_tests++;
            if (IV !== 1'b0) begin
                n_fail++;
                $display("FAIL hunt[%0d]: got IV=%b want 0", i, IV);
            end
        end
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        n_tests++;
        if ({IV, I, CH} !== {1'b1, 5'h0C, 2'd0}) begin
            n_fail++;
            $display("FAIL hunt_align: got IV=%b I=%h CH=%0d want 1 0c 0", IV, I, CH);
        end
    endtask

    task automatic test_overrun();
        do_reset(); RATE = 2'b10; IR = 1'b0;
        drive_bit(1'b0, 1'b1); drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0); drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, I, CH, OVR} !== {1'b1, 5'h03, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL ovr_first: got IV=%b I=%h CH=%0d OVR=%b want 1 03 0 0", IV, I, CH, OVR);
        end
        drive_bit(1'b0, 1'b0); drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0); drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, I, CH, OVR} !== {1'b1, 5'h05, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL ovr_second: got IV=%b I=%h CH=%0d OVR=%b want 1 05 1 1", IV, I, CH, OVR);
        end
        IR = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({IV, OVR} !== 2'b01) begin
            n_fail++;
            $display("FAIL ovr_sticky: got IV=%b OVR=%b want 0 1", IV, OVR);
        end
    endtask

    task automatic test_early_fs();
        do_reset(); RATE = 2'b10; IR = 1'b1;
        drive_bit(1'b1, 1'b1); drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0); drive_bit(1'b0, 1'b0);
        n_tests++;
        if ({IV, I, CH} !== {1'b1, 5'h0E, 2'd0}) begin
            n_fail++;
            $display("FAIL early_c0: got IV=%b I=%h CH=%0d want 1 0e 0", IV, I, CH);
        end
        drive_bit(1'b1, 1'b0); drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b1);
        n_tests++;
        if ({IV, FERR} !== {1'b0, CHK}) begin
            n_fail++;
            $display("FAIL early_ferr: got IV=%b FERR=%b want 0 %b", IV, FERR, CHK);
        end
        drive_bit(1'b0, 1'b0);
        n_tests++;
        if (FERR !== 1'b0) begin
            n_fail++;
            $display("FAIL early_ferr_clr: got FERR=%b want 0", FERR);
        end
        drive_bit(1'b0, 1'b0); drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, I, CH} !== {1'b1, 5'h09, 2'd0}) begin
            n_fail++;
            $display("FAIL early_realign: got IV=%b I=%h CH=%0d want 1 09 0", IV, I, CH);
        end
    endtask

    task automatic test_fs_on_last_bit();
        do_reset(); RATE = 2'b10; IR = 1'b1;
        drive_bit(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b1);
        n_tests++;
        if (IV !== 1'b0) begin
            n_fail++;
            $display("FAIL fs_last_drop: got IV=%b want 0", IV);
        end
        drive_bit(1'b0, 1'b0); drive_bit(1'b1, 1'b0); drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, I, CH} !== {1'b1, 5'h0B, 2'd0}) begin
            n_fail++;
            $display("FAIL fs_last_new: got IV=%b I=%h CH=%0d want 1 0b 0", IV, I, CH);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); RATE = 2'b10; IR = 1'b0;
        drive_bit(1'b1, 1'b1); drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0); drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, I, CH} !== {1'b1, 5'h09, 2'd0}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got IV=%b I=%h CH=%0d want 1 09 0", IV, I, CH);
        end
        drive_bit(1'b1, 1'b0); drive_bit(1'b1, 1'b0);
        do_reset();
        n_tests++;
        if ({I, CH, IV, OVR, FERR} !== 10'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got I=%h CH=%0d IV=%b OVR=%b FERR=%b want all 0", I, CH, IV, OVR, FERR);
        end
        IR = 1'b1;
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        n_tests++;
        if (IV !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_hunt: got IV=%b want 0", IV);
        end
        drive_bit(1'b1, 1'b1); drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0); drive_bit(1'b1, 1'b0);
        n_tests++;
        if ({IV, I, CH} !== {1'b1, 5'h0D, 2'd0}) begin
            n_fail++;
            $display("FAIL rstmid_resync: got IV=%b I=%h CH=%0d want 1 0d 0", IV, I, CH);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_four_bit();
        test_rate_switch();
        test_back_to_back();
        test_hunt();
        test_overrun();
        test_early_fs();
        test_fs_on_last_bit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
